// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and constants for the UART auto-baud detector.
//  Revision : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_LOW0  = 3'd2,
      ST_HIGH1 = 3'd3,
      ST_LOW2  = 3'd4,
      ST_CHECK = 3'd5,
      ST_LOCK  = 3'd6,
      ST_ERR   = 3'd7
   } ab_state_t;

   localparam int OSR              = 16;
   localparam int OSR_SHIFT        = $clog2(OSR);
   localparam int DVSR_W_DEF       = 11;
   localparam int DEFAULT_DVSR_DEF = 325;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Brief    : 2-FF synchronizer for raw rx plus single-cycle edge pulses.
//  Revision : 1.0
// ============================================================================
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   // Resets to idle-high so a released reset never looks like a start edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         dly_q  <= 1'b1;
      end else begin
         meta_q <= rx;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign rise_o = ~dly_q &  sync_q;
   assign fall_o =  dly_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_autobaud.sv
`default_nettype none
// ============================================================================
//  Module   : uart_autobaud
//  Brief    : Measures a 0x55 sync character and derives the 16x baud divisor.
//  Revision : 1.0
// ============================================================================
module uart_autobaud
   import uart_pkg::*;
#(
   parameter int DVSR_W       = DVSR_W_DEF,
   parameter int CNT_W        = DVSR_W + 4,
   parameter int TOL_SHIFT    = 3,
   parameter int MIN_CNT      = 32,
   parameter int DEFAULT_DVSR = DEFAULT_DVSR_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              start,
   input  logic              abort,
   output logic [DVSR_W-1:0] dvsr_out,
   output logic              locked,
   output logic              busy,
   output logic              err
);

   localparam logic [CNT_W-1:0]  c_cnt_max = '1;
   localparam logic [CNT_W+1:0]  c_q_max   = (CNT_W+2)'(2**DVSR_W);

   ab_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt0_q, cnt0_d;
   logic [CNT_W-1:0]   cnt1_q, cnt1_d;
   logic [CNT_W-1:0]   cnt2_q, cnt2_d;
   logic [DVSR_W-1:0]  dvsr_q, dvsr_d;
   logic               locked_q, locked_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic               w_rise;
   logic               w_fall;
   logic [CNT_W-1:0]   w_tol;
   logic [CNT_W-1:0]   w_diff1;
   logic [CNT_W-1:0]   w_diff2;
   logic               w_pass;
   logic [CNT_W:0]     w_sum;
   logic [CNT_W:0]     w_per;
   logic [CNT_W+1:0]   w_q;
   logic [DVSR_W-1:0]  w_dvsr;

   uart_rx_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .rx     (rx),
      .rise_o (w_rise),
      .fall_o (w_fall)
   );

   // Validation: low pulse long enough, both other bits within 1/2^TOL_SHIFT of it.
   assign w_tol   = cnt0_q >> TOL_SHIFT;
   assign w_diff1 = (cnt1_q >= cnt0_q) ? (cnt1_q - cnt0_q) : (cnt0_q - cnt1_q);
   assign w_diff2 = (cnt2_q >= cnt0_q) ? (cnt2_q - cnt0_q) : (cnt0_q - cnt2_q);
   assign w_pass  = (cnt0_q >= CNT_W'(MIN_CNT)) && (w_diff1 <= w_tol) && (w_diff2 <= w_tol);

   // Bit period is the rounded mean of the two low pulses; divisor is period/OSR rounded, minus one.
   assign w_sum  = {1'b0, cnt0_q} + {1'b0, cnt2_q};
   assign w_per  = (w_sum + (CNT_W+1)'(1)) >> 1;
   assign w_q    = ({1'b0, w_per} + (CNT_W+2)'(OSR / 2)) >> OSR_SHIFT;
   assign w_dvsr = (w_q > c_q_max) ? {DVSR_W{1'b1}} : DVSR_W'(w_q - (CNT_W+2)'(1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;
      cnt2_d   = cnt2_q;
      dvsr_d   = dvsr_q;
      locked_d = locked_q;
      busy_d   = busy_q;
      err_d    = err_q;
      if (abort) begin
         state_d  = ST_IDLE;
         locked_d = 1'b0;
         err_d    = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_LOCK, ST_ERR: begin
               if (start) begin
                  state_d  = ST_ARM;
                  locked_d = 1'b0;
                  err_d    = 1'b0;
                  busy_d   = 1'b1;
               end
            end
            ST_ARM: begin
               if (w_fall) begin
                  state_d = ST_LOW0;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_LOW0, ST_HIGH1, ST_LOW2: begin
               if ((state_q == ST_HIGH1) ? w_fall : w_rise) begin
                  cnt_d = CNT_W'(1);
                  if (state_q == ST_LOW0) begin
                     cnt0_d  = cnt_q;
                     state_d = ST_HIGH1;
                  end else if (state_q == ST_HIGH1) begin
                     cnt1_d  = cnt_q;
                     state_d = ST_LOW2;
                  end else begin
                     cnt2_d  = cnt_q;
                     state_d = ST_CHECK;
                  end
               end else if (cnt_q == c_cnt_max) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_CHECK: begin
               busy_d = 1'b0;
               if (w_pass) begin
                  state_d  = ST_LOCK;
                  dvsr_d   = w_dvsr;
                  locked_d = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
         cnt2_q   <= '0;
         dvsr_q   <= DVSR_W'(DEFAULT_DVSR);
         locked_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
         cnt2_q   <= cnt2_d;
         dvsr_q   <= dvsr_d;
         locked_q <= locked_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign dvsr_out = dvsr_q;
   assign locked   = locked_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_autobaud
//  Brief    : Directed self-checking bench for the UART auto-baud detector.
//  Revision : 1.0
// ============================================================================
module tb_uart_autobaud;

   logic        clk;
   logic        reset;
   logic        rx;
   logic        start;
   logic        abort;
   logic [10:0] dvsr_out;
   logic        locked;
   logic        busy;
   logic        err;

   int checks;
   int errors;

   uart_autobaud dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .start    (start),
      .abort    (abort),
      .dvsr_out (dvsr_out),
      .locked   (locked),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drives low/high/low pulses of exact clock counts, then returns rx to idle.
   task automatic send(input int l0, input int h1, input int l2);
      rx = 1'b0; cycles(l0);
      rx = 1'b1; cycles(h1);
      rx = 1'b0; cycles(l2);
      rx = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n;
      n = 0;
      while (busy === 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      rx     = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      cycles(4);
      reset = 1'b1;
      cycles(1);

      // Reset values, idle line produces no activity.
      check("rst_dvsr",   32'(dvsr_out), 32'd325);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_busy",   {31'd0, busy},   32'd0);
      check("rst_err",    {31'd0, err},    32'd0);
      cycles(20);
      check("idle_busy",  {31'd0, busy},   32'd0);

      // 9600 baud at 50 MHz.
      pulse_start();
      check("arm_busy", {31'd0, busy}, 32'd1);
      send(5208, 5208, 5208);
      wait_done("9600_done", 50);
      check("9600_locked", {31'd0, locked}, 32'd1);
      check("9600_dvsr",   32'(dvsr_out),   32'd325);
      check("9600_err",    {31'd0, err},    32'd0);

      // 115200 baud; re-arm drops locked but holds the divisor.
      cycles(10);
      pulse_start();
      check("rearm_locked", {31'd0, locked}, 32'd0);
      check("rearm_dvsr",   32'(dvsr_out),   32'd325);
      send(434, 434, 434);
      wait_done("115k_done", 50);
      check("115k_locked", {31'd0, locked}, 32'd1);
      check("115k_dvsr",   32'(dvsr_out),   32'd26);

      // Mismatched bit1 rejected, divisor held.
      cycles(10);
      pulse_start();
      send(434, 500, 434);
      wait_done("mis_done", 50);
      check("mis_err",    {31'd0, err},    32'd1);
      check("mis_locked", {31'd0, locked}, 32'd0);
      check("mis_dvsr",   32'(dvsr_out),   32'd26);

      // Tolerance edge: 434>>3 = 54, diff 54 accepted, 55 rejected.
      cycles(10);
      pulse_start();
      send(434, 488, 434);
      wait_done("tol_in_done", 50);
      check("tol_in_locked", {31'd0, locked}, 32'd1);
      check("tol_in_err",    {31'd0, err},    32'd0);
      cycles(10);
      pulse_start();
      send(434, 434, 379);
      wait_done("tol_out_done", 50);
      check("tol_out_err", {31'd0, err}, 32'd1);

      // Too-short low pulse, then exactly MIN_CNT accepted (per=32, q=2, dvsr=1).
      cycles(10);
      pulse_start();
      send(20, 20, 20);
      wait_done("short_done", 50);
      check("short_err", {31'd0, err}, 32'd1);
      cycles(10);
      pulse_start();
      send(32, 32, 32);
      wait_done("min_done", 50);
      check("min_locked", {31'd0, locked}, 32'd1);
      check("min_dvsr",   32'(dvsr_out),   32'd1);

      // Line stuck low saturates the counter.
      cycles(10);
      pulse_start();
      rx = 1'b0;
      wait_done("stuck_done", 33000);
      check("stuck_err",  {31'd0, err},  32'd1);
      check("stuck_dvsr", 32'(dvsr_out), 32'd1);
      rx = 1'b1;
      cycles(10);

      // Abort during HIGH1.
      pulse_start();
      rx = 1'b0; cycles(434);
      rx = 1'b1; cycles(100);
      check("hi1_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy",   {31'd0, busy},   32'd0);
      check("abort_locked", {31'd0, locked}, 32'd0);
      check("abort_err",    {31'd0, err},    32'd0);
      check("abort_dvsr",   32'(dvsr_out),   32'd1);
      send(434, 434, 434);
      cycles(20);
      check("idle_no_lock", {31'd0, locked}, 32'd0);

      // Start and abort together: abort wins.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("both_busy", {31'd0, busy}, 32'd0);

      // Reset during LOW2, then a fresh measurement.
      pulse_start();
      rx = 1'b0; cycles(434);
      rx = 1'b1; cycles(434);
      rx = 1'b0; cycles(100);
      reset = 1'b0;
      #1;
      check("mid_rst_dvsr",   32'(dvsr_out),   32'd325);
      check("mid_rst_busy",   {31'd0, busy},   32'd0);
      check("mid_rst_locked", {31'd0, locked}, 32'd0);
      check("mid_rst_err",    {31'd0, err},    32'd0);
      @(negedge clk);
      rx = 1'b1;
      cycles(2);
      reset = 1'b1;
      cycles(5);
      pulse_start();
      send(434, 434, 434);
      wait_done("post_rst_done", 50);
      check("post_rst_locked", {31'd0, locked}, 32'd1);
      check("post_rst_dvsr",   32'(dvsr_out),   32'd26);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
